// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: shift-register scoreboard driving RAW stalls, branch squash and halt drain.
// Zero-latency combinational hold/flush/bubble outputs; scoreboard and FSM advance every clk edge, no backpressure.
module pipe_hazard_ctrl #(
  parameter int DEPTH     = 3,
  parameter int RADDR_W   = 4,
  parameter int FWD       = 0,
  parameter int RF_BYPASS = 1,
  parameter int BR_IDX    = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_src1,
  input  logic               id_src1_used,
  input  logic [RADDR_W-1:0] id_src2,
  input  logic               id_src2_used,
  input  logic [RADDR_W-1:0] id_dst,
  input  logic               id_we,
  input  logic               id_load,
  input  logic               id_hlt,
  input  logic               br_taken,
  output logic               pc_hold,
  output logic               if_id_hold,
  output logic               if_id_flush,
  output logic               id_ex_bubble,
  output logic [DEPTH-1:0]   kill_vec,
  output logic               hlt_out,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic               v;
    logic               we;
    logic [RADDR_W-1:0] dst;
    logic               ld;
    logic               hlt;
  } sb_ent_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  sb_ent_t sb_q [DEPTH];
  sb_ent_t sb_d [DEPTH];
  state_t  state_q, state_d;
  logic    hazard;
  logic    stall;
  logic    any_hlt;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_q[i].v && sb_q[i].we &&
          ((id_src1_used && sb_q[i].dst == id_src1) ||
           (id_src2_used && sb_q[i].dst == id_src2))) begin
        // With forwarding only a load still in ID/EX cannot supply its result in time.
        if (FWD != 0) begin
          if (i == 0 && sb_q[i].ld) hazard = 1'b1;
        end else if (!(RF_BYPASS != 0 && i == DEPTH-1)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall        = id_valid & hazard & ~br_taken & (state_q == RUN);
  assign pc_hold      = stall | (state_q != RUN);
  assign if_id_hold   = stall;
  assign if_id_flush  = br_taken;
  assign id_ex_bubble = stall | br_taken | ~id_valid | (state_q != RUN);
  assign hlt_out      = (state_q == HALTED);

  always_comb begin
    kill_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_vec[i] = br_taken && (i < BR_IDX);
    end
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      sb_d[j] = '0;
    end
    if (!id_ex_bubble) begin
      sb_d[0].v   = 1'b1;
      sb_d[0].we  = id_we;
      sb_d[0].dst = id_dst;
      sb_d[0].ld  = id_load;
      sb_d[0].hlt = id_hlt;
    end
    for (int j = 1; j < DEPTH; j++) begin
      if (!kill_vec[j-1]) sb_d[j] = sb_q[j-1];
    end
  end

  always_comb begin
    state_d = state_q;
    any_hlt = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      any_hlt = any_hlt | (sb_d[j].v & sb_d[j].hlt);
    end
    case (state_q)
      RUN:    if (!id_ex_bubble && id_hlt) state_d = DRAIN;
      // Only one HLT can be in flight; if a branch squashed it, resume fetching.
      DRAIN: begin
        if (sb_d[DEPTH-1].v && sb_d[DEPTH-1].hlt) state_d = HALTED;
        else if (!any_hlt)                         state_d = RUN;
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      stall_cnt <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        sb_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations share stimulus; a timestamp-based reference model feeds per-cycle expectations to a monitor.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
  logic       id_src1_used = 1'b0, id_src2_used = 1'b0;
  logic       id_we = 1'b0, id_load = 1'b0, id_hlt = 1'b0, br_taken = 1'b0;

  logic       ph0, ih0, ff0, bb0, ho0;
  logic [2:0] kv0;
  logic [1:0] sc0;
  logic       ph1, ih1, ff1, bb1, ho1;
  logic [3:0] kv1;
  logic [15:0] sc1;
  logic [31:0] act0, act1;

  always #10 clk = ~clk;

  pipe_hazard_ctrl #(.DEPTH(3), .RADDR_W(4), .FWD(0), .RF_BYPASS(1), .BR_IDX(1), .CNT_W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dst(id_dst), .id_we(id_we), .id_load(id_load),
    .id_hlt(id_hlt), .br_taken(br_taken), .pc_hold(ph0), .if_id_hold(ih0), .if_id_flush(ff0),
    .id_ex_bubble(bb0), .kill_vec(kv0), .hlt_out(ho0), .stall_cnt(sc0));

  pipe_hazard_ctrl #(.DEPTH(4), .RADDR_W(4), .FWD(1), .RF_BYPASS(1), .BR_IDX(2), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dst(id_dst), .id_we(id_we), .id_load(id_load),
    .id_hlt(id_hlt), .br_taken(br_taken), .pc_hold(ph1), .if_id_hold(ih1), .if_id_flush(ff1),
    .id_ex_bubble(bb1), .kill_vec(kv1), .hlt_out(ho1), .stall_cnt(sc1));

  assign act0 = {3'b0, ph0, ih0, ff0, bb0, 5'b0, kv0, ho0, 14'b0, sc0};
  assign act1 = {3'b0, ph1, ih1, ff1, bb1, 4'b0, kv1, ho1, sc1};

  // Model configuration per instance: depth, forwarding, bypass, branch index, counter ceiling.
  int cD[2]   = '{3, 4};
  int cF[2]   = '{0, 1};
  int cB[2]   = '{1, 1};
  int cBR[2]  = '{1, 2};
  int cMAX[2] = '{3, 65535};

  typedef struct {
    int       inst;
    int       t;
    bit       we;
    bit [3:0] dst;
    bit       ld;
    bit       hlt;
  } rec_t;

  rec_t        fl[$];
  bit          halted[2];
  int          cnt[2];
  int          cyc = 0;
  logic [31:0] q0[$], q1[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // An instruction issued in cycle t sits in scoreboard entry k during cycle t+1+k.
  task automatic model_step(input int m, output logic [31:0] e);
    int idx;
    bit haz, drn, run, stall, bub;
    logic [7:0] kv;
    haz = 0;
    drn = 0;
    for (int k = fl.size() - 1; k >= 0; k--)
      if (fl[k].inst == m && cyc - fl[k].t - 1 >= cD[m]) fl.delete(k);
    for (int k = 0; k < fl.size(); k++) begin
      if (fl[k].inst == m) begin
        idx = cyc - fl[k].t - 1;
        if (fl[k].hlt) begin
          if (idx == cD[m] - 1) halted[m] = 1;
          else drn = 1;
        end
        if (fl[k].we && ((id_src1_used && fl[k].dst == id_src1) || (id_src2_used && fl[k].dst == id_src2)) &&
            (cF[m] != 0 ? (idx == 0 && fl[k].ld) : !(cB[m] != 0 && idx == cD[m] - 1)))
          haz = 1;
      end
    end
    run   = !halted[m] && !drn;
    stall = id_valid && haz && !br_taken && run;
    bub   = stall || br_taken || !id_valid || !run;
    kv    = br_taken ? 8'((1 << cBR[m]) - 1) : 8'h0;
    e     = {3'b0, stall || !run, stall, br_taken, bub, kv, halted[m], 16'(cnt[m])};
    if (br_taken)
      for (int k = fl.size() - 1; k >= 0; k--)
        if (fl[k].inst == m && cyc - fl[k].t - 1 < cBR[m]) fl.delete(k);
    if (!bub) fl.push_back('{inst: m, t: cyc, we: id_we, dst: id_dst, ld: id_load, hlt: id_hlt});
    if (stall && cnt[m] < cMAX[m]) cnt[m]++;
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic s1u, input logic [3:0] s2,
                       input logic s2u, input logic [3:0] d, input logic we, input logic ld,
                       input logic hl, input logic br);
    logic [31:0] e;
    @(posedge clk);
    #1;
    id_valid = v; id_src1 = s1; id_src1_used = s1u; id_src2 = s2; id_src2_used = s2u;
    id_dst = d; id_we = we; id_load = ld; id_hlt = hl; br_taken = br;
    model_step(0, e);
    q0.push_back(e);
    model_step(1, e);
    q1.push_back(e);
    cyc++;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    fl.delete();
    q0.delete();
    q1.delete();
    halted = '{0, 0};
    cnt    = '{0, 0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    id_valid = 1'b1; id_src1_used = 1'b0; id_src2_used = 1'b0; id_we = 1'b0;
    id_load = 1'b0; id_hlt = 1'b0; br_taken = 1'b0;
    model_reset();
    #2;
    chk("u0 reset outputs", act0, 32'h0);
    chk("u1 reset outputs", act1, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("u0 outputs", act0, e);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("u1 outputs", act1, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // ADD R1 then SUB R2,R1,R3 held in ID until it issues.
    drive(1, 5, 1, 6, 1, 1, 1, 0, 0, 0);
    repeat (3) drive(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
    repeat (4) idle();
    #2;
    chk("u0 stall_cnt add-sub", 32'(sc0), 32'd2);
    chk("u1 stall_cnt add-sub", 32'(sc1), 32'd0);

    // LW R4 then ADD R5,R4,R4: u1 gets one load-use stall, u0 saturates at 3.
    drive(1, 7, 1, 0, 0, 4, 1, 1, 0, 0);
    repeat (3) drive(1, 4, 1, 4, 1, 5, 1, 0, 0, 0);
    repeat (4) idle();
    #2;
    chk("u0 stall_cnt saturate", 32'(sc0), 32'd3);
    chk("u1 stall_cnt load-use", 32'(sc1), 32'd1);

    // Taken branch with a RAW hazard sitting in ID.
    drive(1, 5, 1, 6, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0, 1);
    #2;
    chk("u0 kill_vec branch", 32'(kv0), 32'd1);
    chk("u1 kill_vec branch", 32'(kv1), 32'd3);
    chk("u0 branch flush/bubble/hold", {29'b0, ff0, bb0, ih0}, 32'b110);
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
    #2;
    chk("u0 no hazard after squash", 32'(ih0), 32'd0);
    repeat (3) idle();

    // HLT squashed while draining: fetch must resume.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 8, 1, 9, 1, 7, 1, 0, 0, 0);
    #2;
    chk("u0 resume after killed hlt", {29'b0, ph0, ho0, bb0}, 32'd0);
    chk("u1 resume after killed hlt", {29'b0, ph1, ho1, bb1}, 32'd0);
    repeat (3) idle();

    // Asynchronous reset in the middle of a stall.
    drive(1, 5, 1, 6, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
    #2;
    chk("u0 stalling before async reset", 32'(ih0), 32'd1);
    #1;
    rst_n = 1'b0;
    #2;
    chk("u0 async reset outputs", act0, 32'h0);
    chk("u1 async reset outputs", act1, 32'h0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // HLT drains DEPTH-1 cycles, then halts for good.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    #2;
    chk("u0 still draining", {30'b0, ho0, ph0}, 32'b01);
    idle();
    #2;
    chk("u0 halted", 32'(ho0), 32'd1);
    idle();
    #2;
    chk("u1 halted", 32'(ho1), 32'd1);
    repeat (4) drive(1, 2, 1, 3, 1, 4, 1, 0, 0, 0);

    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int n = 0; n < 200; n++) begin
        drive($urandom_range(0, 9) < 8,
              4'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
              4'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
              4'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0,
              $urandom_range(0, 7) == 0);
      end
    end

    @(negedge clk);
    #2;
    chk("u0 expectations consumed", 32'(q0.size()), 32'd0);
    chk("u1 expectations consumed", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control block for the 16-bit pipelined core.
- Tracks every instruction in flight after ID in a shift-register scoreboard with one entry per pipe register. Entry 0 = ID/EX, entry DEPTH-1 = last register before writeback.
- From the scoreboard it generates RAW-hazard stalls, squashes on a taken branch, sequences halt drain, and counts stall cycles.
- Sits beside the controller. Drives the hold/flush/bubble inputs of the PC and pipe registers.

Parameters:
- DEPTH, 3, number of scoreboard entries, i.e. pipe registers after ID (legal 2..8).
- RADDR_W, 4, register-address width.
- FWD, 0, 0 = no forwarding (stall on any RAW); 1 = full forwarding (stall only on load-use).
- RF_BYPASS, 1, 1 = register file writes before read in the same cycle, so entry DEPTH-1 never causes a hazard.
- BR_IDX, 1, scoreboard index of the entry that resolves branches (legal 1..DEPTH-1).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  RADDR_W  first source register
- id_src1_used  in  1  src1 is read
- id_src2  in  RADDR_W  second source register
- id_src2_used  in  1  src2 is read
- id_dst  in  RADDR_W  destination register
- id_we  in  1  instruction writes the register file
- id_load  in  1  instruction is a load
- id_hlt  in  1  instruction is HLT
- br_taken  in  1  instruction in entry BR_IDX is a taken branch/jump this cycle
- pc_hold  out  1  PC must not update
- if_id_hold  out  1  IF/ID keeps its contents
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX loads a NOP
- kill_vec  out  DEPTH  bit i=1: pipe register i+1 captures a bubble instead of entry i
- hlt_out  out  1  core halted, pipeline drained
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Entry fields: {v, we, dst, ld, hlt}.
- Reset (async): all entries invalid; FSM = RUN; all outputs 0; stall_cnt = 0.
- Hazard match, entry i: v & we & dst == src, with the corresponding *_used set.
  - FWD=0: check i = 0..DEPTH-1. Exclude i = DEPTH-1 when RF_BYPASS=1.
  - FWD=1: check i = 0 only, and only when ld=1.
- stall = id_valid & hazard & ~br_taken & state==RUN (combinational).
- Outputs are combinational from state, scoreboard, ID inputs and br_taken:
  - pc_hold = stall | state!=RUN
  - if_id_hold = stall
  - if_id_flush = br_taken
  - id_ex_bubble = stall | br_taken | ~id_valid | state!=RUN
  - kill_vec[i] = br_taken & (i < BR_IDX)
- Scoreboard shift at each edge:
  - entry[j] <= entry[j-1], invalidated if kill_vec[j-1] is set.
  - entry[0] <= ID instruction if not id_ex_bubble, else invalid.
  - Oldest entry drops off.
- br_taken has priority over stall. The ID instruction is squashed, not stalled.
- FSM:
  - RUN -> DRAIN when an HLT enters entry 0. No fetch/issue after that point.
  - DRAIN -> HALTED when the HLT entry is at index DEPTH-1.
  - DRAIN -> RUN if the HLT entry is killed by br_taken.
  - HALTED is sticky until reset. hlt_out=1 only in HALTED.
- stall_cnt increments on each cycle stall=1 and saturates at all-ones. It does not count DRAIN/HALTED.
- Register 0 is not special; matches on register 0 stall like any other register.
- Reset mid-operation clears everything on the same edge, including HALTED.

Test Plan:
- FWD=0, DEPTH=3: issue ADD R1 then SUB R2,R1,R3 back-to-back -> stall=1 for 2 cycles (entries 0,1), SUB issues on cycle 3, stall_cnt=2.
- FWD=1: LW R4 then ADD R5,R4,R4 -> exactly 1 stall cycle. ADD R4 then ADD R5,R4 -> 0 stalls.
- br_taken while entry 1 is the branch, with a hazard present in ID -> if_id_flush=1, id_ex_bubble=1, kill_vec=3'b001, stall=0. Next cycle entry 1 invalid and entry 0 invalid.
- HLT issued with no branch -> DEPTH-1 cycles in DRAIN, then hlt_out=1 and pc_hold=1 permanently.
- HLT in entry 0 killed by br_taken (BR_IDX=1) -> FSM returns to RUN, hlt_out stays 0, fetch resumes next cycle.
- CNT_W=2 with 5 consecutive stall cycles -> stall_cnt reaches 3 and holds. Assert rst_n=0 asynchronously mid-stall -> all outputs 0 immediately.
